// File: rtl/max_pool2d_stream_ctrl_if.sv
// rtl/max_pool2d_stream_ctrl_if.sv - control, pixel-in and pooled-out handshake bundle for max_pool2d_stream_ctrl
interface max_pool2d_stream_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  busy, done, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output busy, done, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/max_pool2d_stream_ctrl.sv
// rtl/max_pool2d_stream_ctrl.sv - KxK stride-K max-pool frame sequencer with line buffers; MAXPOOL_RELU_EN fuses a ReLU clamp
module max_pool2d #(
    parameter int K     = 2,
    parameter int WIDTH = 16
) (
    input  logic [K*K*WIDTH-1:0] window,
    output logic signed [WIDTH-1:0] out_max
);
    // Strict greater-than so ties keep the earliest element.
    always_comb begin
        out_max = $signed(window[WIDTH-1:0]);
        for (int i = 1; i < K*K; i++) begin
            if ($signed(window[i*WIDTH +: WIDTH]) > out_max) begin
                out_max = $signed(window[i*WIDTH +: WIDTH]);
            end
        end
    end
endmodule

module max_pool2d_stream_ctrl #(
    parameter int K     = 2,
    parameter int WIDTH = 16,
    parameter int IMG_W = 8,
    parameter int IMG_H = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    max_pool2d_stream_ctrl_if.slave s
);
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RHW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KW  = $clog2(K);

    if ((IMG_W % K) != 0 || (IMG_H % K) != 0) begin : g_bad_cfg
        $error("max_pool2d_stream_ctrl: IMG_W and IMG_H must be multiples of K");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [RHW-1:0]          row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [KW-1:0]           wrow_q, wrow_d, wcol_q, wcol_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic signed [WIDTH-1:0] lb_q [K-1][IMG_W];
    logic signed [WIDTH-1:0] lb_d [K-1][IMG_W];
    logic signed [WIDTH-1:0] sr_q [K-1];
    logic signed [WIDTH-1:0] sr_d [K-1];

    logic [K*K*WIDTH-1:0]    window;
    logic signed [WIDTH-1:0] max_val, pooled;
    logic                    in_ready, accept, last_row_phase, win_done, last_px;

    assign in_ready       = (state_q == RUN) && !(out_valid_q && !s.out_ready);
    assign accept         = s.in_valid && in_ready;
    assign last_row_phase = (wrow_q == KW'(K-1));
    assign win_done       = last_row_phase && (wcol_q == KW'(K-1));
    assign last_px        = (row_q == RHW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

    // Window rows 0..K-2 come from the line buffer, the last row from the shift register plus the live pixel.
    for (genvar wr = 0; wr < K; wr++) begin : g_wr
        for (genvar wc = 0; wc < K; wc++) begin : g_wc
            if (wr < K-1) begin : g_lb
                assign window[(wr*K+wc)*WIDTH +: WIDTH] = lb_q[wr][col_q - CW'(K-1-wc)];
            end else if (wc < K-1) begin : g_sr
                assign window[(wr*K+wc)*WIDTH +: WIDTH] = sr_q[wc];
            end else begin : g_px
                assign window[(wr*K+wc)*WIDTH +: WIDTH] = s.in_data;
            end
        end
    end

    max_pool2d #(.K(K), .WIDTH(WIDTH)) u_pool (
        .window  (window),
        .out_max (max_val)
    );

`ifdef MAXPOOL_RELU_EN
    assign pooled = max_val[WIDTH-1] ? '0 : max_val;
`else
    assign pooled = max_val;
`endif

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        wrow_d      = wrow_q;
        wcol_d      = wcol_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        lb_d        = lb_q;
        sr_d        = sr_q;

        case (state_q)
            IDLE: if (s.start) begin
                state_d = RUN;
                busy_d  = 1'b1;
                row_d   = '0;
                col_d   = '0;
                wrow_d  = '0;
                wcol_d  = '0;
            end
            RUN: if (accept && last_px) state_d = DRAIN;
            DRAIN: if (!out_valid_q || s.out_ready) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (!last_row_phase) begin
                for (int r = 0; r < K-1; r++) begin
                    if (wrow_q == KW'(r)) lb_d[r][col_q] = s.in_data;
                end
            end else if (!win_done) begin
                for (int j = 0; j < K-2; j++) sr_d[j] = sr_q[j+1];
                sr_d[K-2] = s.in_data;
            end
            if (col_q == CW'(IMG_W-1)) begin
                col_d  = '0;
                wcol_d = '0;
                row_d  = (row_q == RHW'(IMG_H-1)) ? '0 : row_q + 1'b1;
                wrow_d = last_row_phase ? '0 : wrow_q + 1'b1;
            end else begin
                col_d  = col_q + 1'b1;
                wcol_d = (wcol_q == KW'(K-1)) ? '0 : wcol_q + 1'b1;
            end
        end

        if (accept && win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = pooled;
            out_last_d  = last_px;
        end else if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            wrow_q      <= '0;
            wcol_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wrow_q      <= wrow_d;
            wcol_q      <= wcol_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        lb_q <= lb_d;
        sr_q <= sr_d;
    end

    assign s.busy      = busy_q;
    assign s.done      = done_q;
    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
endmodule

// File: tb/tb_max_pool2d_stream_ctrl.sv
// tb/tb_max_pool2d_stream_ctrl.sv - table-driven frame bench for max_pool2d_stream_ctrl (K=2, 8x4)
module tb_max_pool2d_stream_ctrl;
    localparam int K = 2, W = 16, IW = 8, IH = 4, NPIX = 32, NOUT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    max_pool2d_stream_ctrl_if #(.WIDTH(W)) bus ();

    max_pool2d_stream_ctrl #(.K(K), .WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int    pat;
        int    mode;
        int    exp [NOUT];
        string name;
    } vec_t;

    vec_t vt [5];
    logic signed [W-1:0] pix [NPIX];
    int got [$];
    int lasts [$];

    task automatic set_pix(input int pat);
        for (int i = 0; i < NPIX; i++) pix[i] = (pat == 1) ? -16'sd5 : W'(i);
        if (pat == 2) begin
            pix[0] = -16'sd32768;
            pix[1] = 16'sd32767;
            pix[8] = -16'sd1;
            pix[9] = 16'sd0;
        end
    endtask

    // mode 0: always valid/ready; 3: out_ready low 10 cycles after first result; 4: random in_valid
    task automatic run_frame(input int mode, input string nm);
        int idx = 0, cyc = 0, stall_left = 0, done_cnt = 0, done_cyc = -1, acc_cyc = -1;
        bit stalled_once = 0;
        got.delete();
        lasts.delete();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, ".busy"}, bus.busy, 1);
        while (cyc < 600 && done_cnt == 0) begin
            if (mode == 3 && !stalled_once && bus.out_valid) begin
                stall_left   = 10;
                stalled_once = 1;
            end
            bus.out_ready = (stall_left == 0);
            bus.in_valid  = (idx < NPIX) && (mode != 4 || $urandom_range(0, 1) == 1);
            bus.in_data   = (idx < NPIX) ? pix[idx] : '0;
            #1;
            if (stall_left > 0) begin
                chk({nm, ".stall_in_ready"}, bus.in_ready, 0);
                chk({nm, ".stall_out_data"}, $signed(bus.out_data), 9);
                stall_left--;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(int'($signed(bus.out_data)));
                lasts.push_back(int'(bus.out_last));
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({nm, ".done_seen"}, done_cnt, 1);
        chk({nm, ".done_cycle"}, done_cyc, acc_cyc + 1);
        chk({nm, ".done_width"}, bus.done, 0);
        chk({nm, ".busy_end"}, bus.busy, 0);
    endtask

    task automatic check_outputs(input string nm, input int exp [NOUT]);
        int lastmask = 0;
        chk({nm, ".count"}, got.size(), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            chk($sformatf("%s.out%0d", nm, i), (i < got.size()) ? got[i] : -99999, exp[i]);
        end
        for (int i = 0; i < got.size(); i++) if (lasts[i] != 0) lastmask |= (1 << i);
        chk({nm, ".last_mask"}, lastmask, 32'h80);
    endtask

    initial begin
        int neg_exp;
        int bad;
`ifdef MAXPOOL_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -5;
`endif
        vt[0] = '{0, 0, '{9, 11, 13, 15, 25, 27, 29, 31}, "ramp"};
        vt[1] = '{1, 0, '{neg_exp, neg_exp, neg_exp, neg_exp, neg_exp, neg_exp, neg_exp, neg_exp}, "neg5"};
        vt[2] = '{2, 0, '{32767, 11, 13, 15, 25, 27, 29, 31}, "signed"};
        vt[3] = '{0, 3, '{9, 11, 13, 15, 25, 27, 29, 31}, "stall"};
        vt[4] = '{0, 4, '{9, 11, 13, 15, 25, 27, 29, 31}, "rand_valid"};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.in_ready", bus.in_ready, 0);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.out_last", bus.out_last, 0);
        chk("rst.out_data", bus.out_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            set_pix(vt[v].pat);
            run_frame(vt[v].mode, vt[v].name);
            check_outputs(vt[v].name, vt[v].exp);
            @(posedge clk); #1;
        end

        set_pix(0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int idx = 0, cyc = 0; idx < 13 && cyc < 100; cyc++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pix[idx];
            #1;
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort.busy", bus.busy, 0);
        chk("abort.out_valid", bus.out_valid, 0);
        chk("abort.in_ready", bus.in_ready, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done || bus.out_valid) bad++;
            @(posedge clk); #1;
        end
        chk("abort.no_leftover", bad, 0);
        run_frame(0, "after_abort");
        check_outputs("after_abort", vt[0].exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
